time_entry: RTL

Button-driven BCD time-setting front end that produces the MM:SS digits consumed by the countdown block.
- Edits four BCD digits in place.
- Hands the value to the countdown with a load/busy handshake.
- Waits out the run, then returns to editing with the last-entered value retained.

---
 rtl/time_entry_if.sv | 27 ++
 rtl/time_entry.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/time_entry_if.sv
// Bundle of button, handshake and digit signals between the time-entry block and its environment.
interface time_entry_if;
  logic       btn_next;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_start;
  logic       busy;
  logic [3:0] bin0;
  logic [3:0] bin1;
  logic [3:0] bin2;
  logic [3:0] bin3;
  logic [1:0] sel;
  logic       load;
  logic       editing;

  // Environment side: drives buttons and busy, observes digits and handshake
  modport master (
    output btn_next, btn_inc, btn_dec, btn_start, busy,
    input  bin0, bin1, bin2, bin3, sel, load, editing
  );

  // Time-entry block side
  modport slave (
    input  btn_next, btn_inc, btn_dec, btn_start, busy,
    output bin0, bin1, bin2, bin3, sel, load, editing
  );
endinterface

// File: rtl/time_entry.sv
// Button-driven MM:SS BCD entry with load/busy handoff to the countdown block.
// Optional feature macro: AUTO_REPEAT_EN (held inc/dec auto-repeat).
module time_entry #(
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input logic         clk,
  input logic         rst_n,
  time_entry_if.slave bus
);

  localparam logic [1:0] S_EDIT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Repeat timing must be nonzero for the repeat counter to make sense
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_cfg_check
    $error("time_entry: REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
  end

  logic [1:0]      state, state_nxt;
  logic [3:0][3:0] dig, dig_nxt;
  logic [1:0]      sel, sel_nxt;
  logic            load, load_nxt;
  logic            editing, editing_nxt;

  logic next_prev, inc_prev, dec_prev, start_prev;
  logic next_ev, inc_ev, dec_ev, start_ev;
  logic inc_step, dec_step;

  assign next_ev  = bus.btn_next  & ~next_prev;
  assign inc_ev   = bus.btn_inc   & ~inc_prev;
  assign dec_ev   = bus.btn_dec   & ~dec_prev;
  assign start_ev = bus.btn_start & ~start_prev;

  // One BCD step up or down with wrap at the digit's top value
  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] top, input logic up);
    if (up) return (d == top) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? top : d - 4'd1;
  endfunction

  // Button history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_prev  <= 1'b0;
      inc_prev   <= 1'b0;
      dec_prev   <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      next_prev  <= bus.btn_next;
      inc_prev   <= bus.btn_inc;
      dec_prev   <= bus.btn_dec;
      start_prev <= bus.btn_start;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  // rpt_cnt == 0 means disarmed; otherwise it counts cycles since the last step
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_on, rpt_on_nxt;
  logic             rpt_fire;
  logic             hold_one;

  assign hold_one = bus.btn_inc ^ bus.btn_dec;

  // Repeat timer: armed by an inc/dec edge, cleared on release, both-held or leaving EDIT
  always_comb begin
    rpt_cnt_nxt = rpt_cnt;
    rpt_on_nxt  = rpt_on;
    rpt_fire    = 1'b0;
    if (state != S_EDIT || !hold_one) begin
      rpt_cnt_nxt = '0;
      rpt_on_nxt  = 1'b0;
    end else if (inc_ev || dec_ev) begin
      rpt_cnt_nxt = CNT_W'(1);
      rpt_on_nxt  = 1'b0;
    end else if (rpt_cnt != '0) begin
      if (rpt_cnt == (rpt_on ? PERIOD_C : DELAY_C)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_nxt = CNT_W'(1);
        rpt_on_nxt  = 1'b1;
      end else begin
        rpt_cnt_nxt = rpt_cnt + CNT_W'(1);
      end
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt_nxt;
      rpt_on  <= rpt_on_nxt;
    end
  end

  assign inc_step = inc_ev | (rpt_fire & bus.btn_inc);
  assign dec_step = dec_ev | (rpt_fire & bus.btn_dec);
`else
  assign inc_step = inc_ev;
  assign dec_step = dec_ev;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EDIT;
      dig     <= '0;
      sel     <= 2'd0;
      load    <= 1'b0;
      editing <= 1'b1;
    end else begin
      state   <= state_nxt;
      dig     <= dig_nxt;
      sel     <= sel_nxt;
      load    <= load_nxt;
      editing <= editing_nxt;
    end
  end

  // Next-state and output logic; start is judged on the pre-update digits
  always_comb begin
    state_nxt   = state;
    dig_nxt     = dig;
    sel_nxt     = sel;
    load_nxt    = load;
    editing_nxt = editing;
    case (state)
      S_EDIT: begin
        if (inc_step ^ dec_step)
          dig_nxt[sel] = bump(dig[sel], (sel == 2'd1) ? 4'd5 : 4'd9, inc_step);
        if (next_ev)
          sel_nxt = sel + 2'd1;
        if (start_ev && (dig != '0)) begin
          state_nxt   = S_LOAD;
          load_nxt    = 1'b1;
          editing_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.busy) begin
          state_nxt = S_RUN;
          load_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        load_nxt = 1'b0;
        if (!bus.busy) begin
          state_nxt   = S_EDIT;
          editing_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = S_EDIT;
        load_nxt    = 1'b0;
        editing_nxt = 1'b1;
      end
    endcase
  end

  assign bus.bin0    = dig[0];
  assign bus.bin1    = dig[1];
  assign bus.bin2    = dig[2];
  assign bus.bin3    = dig[3];
  assign bus.sel     = sel;
  assign bus.load    = load;
  assign bus.editing = editing;

endmodule
